// File: rtl/mem_arb_if.sv
// mem_arb_if: core instruction/data ports and the shared memory bus around mem_arb.
// slave is the arbiter's view, master is the surrounding core/memory view.
interface mem_arb_if #(parameter int AW = 64);
   logic [AW-1:0] im_req_addr;
   logic          im_req_valid;
   logic          im_req_ready;
   logic [63:0]   im_resp_rdata;
   logic          im_resp_valid;
   logic          im_invalidate_req;
   logic          im_invalidate_resp;
   logic [AW-1:0] dm_req_addr;
   logic [63:0]   dm_req_wdata;
   logic [7:0]    dm_req_wmask;
   logic          dm_req_wen;
   logic          dm_req_valid;
   logic          dm_req_ready;
   logic [63:0]   dm_resp_rdata;
   logic          dm_resp_valid;
   logic [AW-1:0] bus_req_addr;
   logic [63:0]   bus_req_wdata;
   logic [7:0]    bus_req_wmask;
   logic          bus_req_wen;
   logic          bus_req_valid;
   logic          bus_req_ready;
   logic [63:0]   bus_resp_rdata;
   logic          bus_resp_valid;
   modport slave (
      input  im_req_addr, im_req_valid, im_invalidate_req,
      input  dm_req_addr, dm_req_wdata, dm_req_wmask, dm_req_wen, dm_req_valid,
      input  bus_req_ready, bus_resp_rdata, bus_resp_valid,
      output im_req_ready, im_resp_rdata, im_resp_valid, im_invalidate_resp,
      output dm_req_ready, dm_resp_rdata, dm_resp_valid,
      output bus_req_addr, bus_req_wdata, bus_req_wmask, bus_req_wen, bus_req_valid
   );
   modport master (
      output im_req_addr, im_req_valid, im_invalidate_req,
      output dm_req_addr, dm_req_wdata, dm_req_wmask, dm_req_wen, dm_req_valid,
      output bus_req_ready, bus_resp_rdata, bus_resp_valid,
      input  im_req_ready, im_resp_rdata, im_resp_valid, im_invalidate_resp,
      input  dm_req_ready, dm_resp_rdata, dm_resp_valid,
      input  bus_req_addr, bus_req_wdata, bus_req_wmask, bus_req_wen, bus_req_valid
   );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: im/dm to shared memory bus arbiter with in-order response routing and im invalidate handshake.
// MEM_ARB_DM_PRIORITY_EN selects fixed dm priority instead of round-robin.
module mem_arb #(
   parameter int OUTSTANDING = 2,
   parameter int AW = 64
) (
   input logic      clk,
   input logic      rst,
   mem_arb_if.slave io
);
   localparam int CW = $clog2(OUTSTANDING + 1);
   typedef enum logic [1:0] {IDLE, DRAIN, ACK} inv_t;
   inv_t state, state_nxt;
   logic [OUTSTANDING-1:0] tags, tags_nxt;
   logic [CW-1:0] count, im_cnt;
   logic lock, lock_dm, grant_dm, im_v, cand_v, full, push, pop, inv_block;
`ifndef MEM_ARB_DM_PRIORITY_EN
   logic rr_dm;
`endif
   assign full = count == CW'(OUTSTANDING);
   assign pop = io.bus_resp_valid && count != '0;
   assign im_v = io.im_req_valid && !inv_block;
`ifdef MEM_ARB_DM_PRIORITY_EN
   assign grant_dm = lock ? lock_dm : io.dm_req_valid;
`else
   assign grant_dm = lock ? lock_dm : io.dm_req_valid && (!im_v || rr_dm);
`endif
   assign cand_v = grant_dm ? io.dm_req_valid : im_v;
   assign push = io.bus_req_valid && io.bus_req_ready;
   // Outputs are forced low while reset is asserted, independent of the inputs.
   assign io.bus_req_valid = rst && cand_v && !full;
   assign io.bus_req_addr = !rst ? '0 : grant_dm ? io.dm_req_addr : io.im_req_addr;
   assign io.bus_req_wdata = rst && grant_dm ? io.dm_req_wdata : '0;
   assign io.bus_req_wmask = rst && grant_dm ? io.dm_req_wmask : '0;
   assign io.bus_req_wen = rst && grant_dm && io.dm_req_wen;
   assign io.im_req_ready = rst && !grant_dm && io.bus_req_ready && !full && !inv_block;
   assign io.dm_req_ready = rst && grant_dm && io.bus_req_ready && !full;
   assign io.im_resp_valid = pop && !tags[0];
   assign io.dm_resp_valid = pop && tags[0];
   assign io.im_resp_rdata = rst ? io.bus_resp_rdata : '0;
   assign io.dm_resp_rdata = rst ? io.bus_resp_rdata : '0;
   // Head of the tag FIFO lives at bit 0; a pop shifts, a push lands after the last live entry.
   always_comb begin
      tags_nxt = pop ? tags >> 1 : tags;
      for (int i = 0; i < OUTSTANDING; i++)
         if (push && CW'(i) == count - CW'(pop)) tags_nxt[i] = grant_dm;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         tags <= '0;
         count <= '0;
         im_cnt <= '0;
         lock <= 1'b0;
         lock_dm <= 1'b0;
      end else begin
         tags <= tags_nxt;
         count <= count + CW'(push) - CW'(pop);
         im_cnt <= im_cnt + CW'(push && !grant_dm) - CW'(pop && !tags[0]);
         if (push) lock <= 1'b0;
         else if (io.bus_req_valid) begin
            lock <= 1'b1;
            lock_dm <= grant_dm;
         end
      end
`ifndef MEM_ARB_DM_PRIORITY_EN
   always_ff @(posedge clk or negedge rst)
      if (!rst) rr_dm <= 1'b0;
      else if (push) rr_dm <= !grant_dm;
`endif
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= state_nxt;
   always_comb
      state_nxt = state == ACK ? IDLE :
                  (state == DRAIN || io.im_invalidate_req) ? (im_cnt == '0 ? ACK : DRAIN) : IDLE;
   // im is blocked from the first cycle the invalidate request is seen until the ack has gone out.
   always_comb begin
      inv_block = state != IDLE || io.im_invalidate_req;
      io.im_invalidate_resp = state == ACK;
   end
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed table, hand sequences and random traffic for mem_arb,
// all checked against a queue-based reference model.
module tb_mem_arb;
   localparam int OUT = 2;
`ifdef MEM_ARB_DM_PRIORITY_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif
   typedef struct {
      bit imv; logic [63:0] ima; bit dmv; logic [63:0] dma; bit rdy; bit rspv; logic [63:0] rd;
      bit e_bv; logic [63:0] e_addr; bit e_wen; bit e_imr; bit e_dmr; bit e_imrv; bit e_dmrv;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int tests = 0;
   int failed = 0;
   vec_t tbl[8];
   int q[$];
   bit m_rr, m_lock, m_lock_dm, m_busy, m_ack;
   bit e_gdm, e_bv, e_pop, e_imr, e_dmr;
   bit g, gp, acc_im, acc_dm, inv_done;
   mem_arb_if #(.AW(64)) io();
   mem_arb #(.OUTSTANDING(OUT), .AW(64)) dut (.clk(clk), .rst(rst), .io(io.slave));
   always #5 clk = ~clk;
   task automatic chk(string n, logic [63:0] a, logic [63:0] e);
      tests++;
      if (a !== e) begin
         failed++;
         $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
      end
   endtask
   task automatic mreset();
      q.delete();
      m_rr = 0; m_lock = 0; m_lock_dm = 0; m_busy = 0; m_ack = 0;
   endtask
   task automatic drive(bit imv, logic [63:0] ima, bit dmv, logic [63:0] dma, bit rdy, bit rspv, logic [63:0] rd);
      io.im_req_valid = imv; io.im_req_addr = ima;
      io.dm_req_valid = dmv; io.dm_req_addr = dma;
      io.dm_req_wdata = ~dma; io.dm_req_wmask = dma[15:8]; io.dm_req_wen = dma[12];
      io.bus_req_ready = rdy; io.bus_resp_valid = rspv; io.bus_resp_rdata = rd;
   endtask
   // Reference: a queue of outstanding sources, a "who goes next" bit, a stall lock and an invalidate flag.
   task automatic settle();
      bit blk, imv, full;
      #4;
      blk = m_busy | m_ack | io.im_invalidate_req;
      imv = io.im_req_valid & !blk;
      full = q.size() >= OUT;
      e_gdm = m_lock ? m_lock_dm : io.dm_req_valid & (!imv | PRIO | m_rr);
      e_bv = (e_gdm ? io.dm_req_valid : imv) & !full;
      e_pop = io.bus_resp_valid & (q.size() > 0);
      e_imr = !e_gdm & io.bus_req_ready & !full & !blk;
      e_dmr = e_gdm & io.bus_req_ready & !full;
      chk("bus_req_valid", io.bus_req_valid, e_bv);
      chk("bus_req_addr", io.bus_req_addr, e_gdm ? io.dm_req_addr : io.im_req_addr);
      chk("bus_req_wdata", io.bus_req_wdata, e_gdm ? io.dm_req_wdata : 64'h0);
      chk("bus_req_wmask_wen", {io.bus_req_wmask, io.bus_req_wen}, e_gdm ? {io.dm_req_wmask, io.dm_req_wen} : 9'h0);
      chk("im_req_ready", io.im_req_ready, e_imr);
      chk("dm_req_ready", io.dm_req_ready, e_dmr);
      chk("im_resp_valid", io.im_resp_valid, e_pop && q[0] == 0);
      chk("dm_resp_valid", io.dm_resp_valid, e_pop && q[0] == 1);
      chk("im_resp_rdata", io.im_resp_rdata, io.bus_resp_rdata);
      chk("dm_resp_rdata", io.dm_resp_rdata, io.bus_resp_rdata);
      chk("im_invalidate_resp", io.im_invalidate_resp, m_ack);
   endtask
   task automatic adv();
      int n_im = 0;
      bit xfer;
      foreach (q[i]) if (q[i] == 0) n_im++;
      xfer = e_bv & io.bus_req_ready;
      if (e_pop) void'(q.pop_front());
      if (xfer) begin q.push_back(int'(e_gdm)); m_rr = !e_gdm; end
      if (e_bv && !io.bus_req_ready) begin m_lock = 1; m_lock_dm = e_gdm; end
      else if (xfer) m_lock = 0;
      if (m_ack) begin m_ack = 0; m_busy = 0; end
      else if ((m_busy || io.im_invalidate_req) && n_im == 0) m_ack = 1;
      else if (io.im_invalidate_req) m_busy = 1;
      @(posedge clk);
      #1;
   endtask
   initial begin
      drive(0, 0, 0, 0, 0, 0, 0);
      io.im_invalidate_req = 0;
      tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      for (int i = 1; i <= 4; i++) begin
         g = PRIO || (i % 2 == 0);
         gp = PRIO || (i % 2 == 1);
         tbl[i] = '{1, 64'h2000, 1, 64'h3000, 1, i >= 2, 64'(i) * 64'h1111,
                    1, g ? 64'h3000 : 64'h2000, g, !g, g, (i >= 2) && !gp, (i >= 2) && gp};
      end
      tbl[5] = '{0, 0, 0, 0, 0, 1, 64'hDEAD, 0, 0, 0, 0, 0, 0, 1};
      tbl[6] = '{1, 64'h1000, 0, 0, 1, 0, 0, 1, 64'h1000, 0, 1, 0, 0, 0};
      tbl[7] = '{0, 0, 0, 0, 0, 1, 64'hDEADBEEF, 0, 0, 0, 0, 0, 1, 0};
      repeat (2) @(posedge clk);
      #1 rst = 1;
      mreset();
      foreach (tbl[k]) begin
         drive(tbl[k].imv, tbl[k].ima, tbl[k].dmv, tbl[k].dma, tbl[k].rdy, tbl[k].rspv, tbl[k].rd);
         settle();
         chk("tbl bus_req_valid", io.bus_req_valid, tbl[k].e_bv);
         chk("tbl bus_req_addr", io.bus_req_addr, tbl[k].e_addr);
         chk("tbl bus_req_wen", io.bus_req_wen, tbl[k].e_wen);
         chk("tbl im_req_ready", io.im_req_ready, tbl[k].e_imr);
         chk("tbl dm_req_ready", io.dm_req_ready, tbl[k].e_dmr);
         chk("tbl im_resp_valid", io.im_resp_valid, tbl[k].e_imrv);
         chk("tbl dm_resp_valid", io.dm_resp_valid, tbl[k].e_dmrv);
         chk("tbl im_resp_rdata", io.im_resp_rdata, tbl[k].rd);
         adv();
      end
      // Stall: im locked in while dm shows up, then dm follows.
      for (int c = 0; c < 4; c++) begin
         drive(1, 64'h4000, c > 0, 64'h5000, c == 3, 0, 0);
         settle();
         chk("stall addr", io.bus_req_addr, 64'h4000);
         chk("stall im_ready", io.im_req_ready, c == 3);
         adv();
      end
      drive(0, 0, 1, 64'h5000, 1, 0, 0);
      settle(); chk("after stall addr", io.bus_req_addr, 64'h5000); chk("after stall dm_ready", io.dm_req_ready, 1); adv();
      // Full with two outstanding; a response frees a slot only from the next cycle.
      drive(1, 64'h6000, 0, 0, 1, 0, 0);
      settle(); chk("full valid", io.bus_req_valid, 0); chk("full readies", {io.im_req_ready, io.dm_req_ready}, 0); adv();
      drive(1, 64'h6000, 0, 0, 1, 1, 64'h77);
      settle(); chk("full pop valid", io.bus_req_valid, 0); chk("full pop im_resp", io.im_resp_valid, 1); adv();
      drive(1, 64'h6000, 0, 0, 1, 0, 0);
      settle(); chk("refill valid", io.bus_req_valid, 1); chk("refill ready", io.im_req_ready, 1); adv();
      drive(0, 0, 0, 0, 0, 1, 64'h88); settle(); chk("drain dm_resp", io.dm_resp_valid, 1); adv();
      settle(); chk("drain im_resp", io.im_resp_valid, 1); adv();
      // Invalidate with one fetch in flight; dm keeps flowing.
      drive(1, 64'h7000, 0, 0, 1, 0, 0); settle(); adv();
      drive(1, 64'h7100, 1, 64'h8000, 1, 0, 0); io.im_invalidate_req = 1;
      settle(); chk("inv dm addr", io.bus_req_addr, 64'h8000); chk("inv dm_ready", io.dm_req_ready, 1);
      chk("inv im_ready", io.im_req_ready, 0); chk("inv resp early", io.im_invalidate_resp, 0); adv();
      drive(1, 64'h7100, 0, 0, 1, 0, 0);
      settle(); chk("inv block", io.bus_req_valid, 0); chk("inv resp wait", io.im_invalidate_resp, 0); adv();
      drive(1, 64'h7100, 0, 0, 1, 1, 64'h99);
      settle(); chk("inv im pop", io.im_resp_valid, 1); chk("inv resp pop", io.im_invalidate_resp, 0); adv();
      drive(1, 64'h7100, 0, 0, 1, 0, 0);
      settle(); chk("inv resp drain", io.im_invalidate_resp, 0); adv();
      settle(); chk("inv resp pulse", io.im_invalidate_resp, 1); chk("inv ack block", io.bus_req_valid, 0); adv();
      io.im_invalidate_req = 0;
      settle(); chk("inv resp done", io.im_invalidate_resp, 0); chk("inv im resume", io.bus_req_addr, 64'h7100);
      chk("inv im resume rdy", io.im_req_ready, 1); adv();
      drive(0, 0, 0, 0, 0, 1, 64'h5); settle(); adv(); settle(); adv();
      drive(0, 0, 0, 0, 0, 0, 0); io.im_invalidate_req = 1;
      settle(); chk("inv idle no resp", io.im_invalidate_resp, 0); adv();
      settle(); chk("inv idle resp", io.im_invalidate_resp, 1); adv();
      io.im_invalidate_req = 0; settle(); adv();
      // Async reset with two outstanding and a stalled request.
      drive(1, 64'hA000, 0, 0, 1, 0, 0); settle(); adv();
      drive(0, 0, 1, 64'hB000, 1, 0, 0); settle(); adv();
      drive(1, 64'hC000, 1, 64'hD000, 1, 0, 64'h1234);
      settle();
      #1 rst = 0;
      #1;
      chk("rst bus_req_valid", io.bus_req_valid, 0);
      chk("rst bus_req_addr", io.bus_req_addr, 0);
      chk("rst bus_req_wdata", io.bus_req_wdata, 0);
      chk("rst wmask_wen", {io.bus_req_wmask, io.bus_req_wen}, 0);
      chk("rst readies", {io.im_req_ready, io.dm_req_ready}, 0);
      chk("rst resp", {io.im_resp_valid, io.dm_resp_valid, io.im_invalidate_resp}, 0);
      chk("rst rdata", io.im_resp_rdata | io.dm_resp_rdata, 0);
      mreset();
      @(posedge clk);
      #1 rst = 1;
      drive(0, 0, 0, 0, 0, 1, 64'hBAD);
      settle(); chk("stray resp", {io.im_resp_valid, io.dm_resp_valid}, 0); adv();
      drive(1, 64'hC000, 1, 64'hD000, 1, 0, 0);
      settle(); chk("post rst grant", io.bus_req_addr, PRIO ? 64'hD000 : 64'hC000); adv();
      drive(0, 0, 0, 0, 0, 1, 64'h1); settle(); adv();
      // Random traffic; requesters hold a request until it is accepted.
      acc_im = 0; acc_dm = 0; inv_done = 0;
      for (int n = 0; n < 3000; n++) begin
         if (!io.im_req_valid || acc_im) begin
            io.im_req_valid = $urandom_range(0, 2) != 0;
            io.im_req_addr = {$urandom, $urandom};
         end
         if (!io.dm_req_valid || acc_dm) begin
            io.dm_req_valid = $urandom_range(0, 2) != 0;
            io.dm_req_addr = {$urandom, $urandom};
            io.dm_req_wdata = {$urandom, $urandom};
            io.dm_req_wmask = 8'($urandom);
            io.dm_req_wen = 1'($urandom);
         end
         io.bus_req_ready = $urandom_range(0, 3) != 0;
         io.bus_resp_valid = $urandom_range(0, 2) == 0;
         io.bus_resp_rdata = {$urandom, $urandom};
         if (inv_done) io.im_invalidate_req = 0;
         else if (!io.im_invalidate_req && $urandom_range(0, 40) == 0) io.im_invalidate_req = 1;
         settle();
         acc_im = io.im_req_valid & e_imr;
         acc_dm = io.dm_req_valid & e_dmr;
         inv_done = m_ack;
         adv();
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Two-to-one memory arbiter directly downstream of the CPU core.
- Merges the core's instruction-memory port (im_*) and data-memory port (dm_*) onto one shared memory bus.
- Tracks outstanding requests in order and routes each bus response back to the requester that issued it.
- Acknowledges instruction-side invalidate requests once no instruction fetch is in flight.

Parameters:
- OUTSTANDING, 2, maximum accepted-but-unanswered bus requests (source-tag FIFO depth, power of 2, >=1)
- AW, 64, address width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- im_req_addr  in  AW  fetch address
- im_req_valid  in  1  fetch request
- im_req_ready  out  1  fetch accepted
- im_resp_rdata  out  64  fetch data
- im_resp_valid  out  1  fetch response
- im_invalidate_req  in  1  invalidate request (level, held until resp)
- im_invalidate_resp  out  1  invalidate done (1-cycle pulse)
- dm_req_addr  in  AW  data address
- dm_req_wdata  in  64  store data
- dm_req_wmask  in  8  byte mask
- dm_req_wen  in  1  write
- dm_req_valid  in  1  data request
- dm_req_ready  out  1  data accepted
- dm_resp_rdata  out  64  load data
- dm_resp_valid  out  1  data response
- bus_req_addr  out  AW  bus address
- bus_req_wdata  out  64  bus write data
- bus_req_wmask  out  8  bus byte mask
- bus_req_wen  out  1  bus write
- bus_req_valid  out  1  bus request
- bus_req_ready  in  1  bus accepts
- bus_resp_rdata  in  64  bus response data
- bus_resp_valid  in  1  bus response (one per accepted request, in order)

Behaviour:
- Reset (rst=0, async): tag FIFO empty, count=0, grant lock cleared, round-robin pointer = im first, invalidate state idle. All outputs 0.
- Transfer happens when bus_req_valid & bus_req_ready.
- Each transfer pushes a 1-bit source tag (0=im, 1=dm) into the FIFO.
- full = (count == OUTSTANDING), evaluated before any pop in that cycle. No push when full, even if a pop occurs the same cycle.
- bus_req_valid = (candidate valid) & !full & !inv_block.
  - inv_block is asserted for the im source only (see invalidate).
- Arbitration (combinational) when not locked:
  - Only one source valid: that source wins.
  - Both valid: the round-robin pointer winner wins. The pointer flips to the other source after each transfer.
- Grant lock:
  - If bus_req_valid & !bus_req_ready, the current grant is registered.
  - It is held until the transfer, so bus_req_* fields stay stable while stalled.
  - The lock clears on the transfer cycle.
- Request field muxing:
  - im grant: addr = im_req_addr, wdata = 0, wmask = 0, wen = 0.
  - dm grant: all dm fields pass through.
- Request readies:
  - im_req_ready = grant_im & bus_req_ready & !full & !inv_block.
  - dm_req_ready = grant_dm & bus_req_ready & !full.
- Responses (zero latency, combinational):
  - On bus_resp_valid with FIFO non-empty: pop the head tag. Assert im_resp_valid if tag=0, dm_resp_valid if tag=1.
  - bus_resp_rdata is driven to both resp_rdata outputs.
  - bus_resp_valid with FIFO empty is discarded (no state change).
- Push and pop in the same cycle: count unchanged.
- Invalidate state machine:
  - IDLE: on im_invalidate_req, go to DRAIN. From this point new im requests are blocked (inv_block=1).
  - DRAIN: once no im tags remain in the FIFO (tracked by an im-outstanding counter), go to ACK.
  - ACK: im_invalidate_resp=1 for one cycle, then return to IDLE.
  - Minimum req-to-resp latency is 1 cycle when nothing is outstanding.
  - dm traffic continues throughout.

Optional Feature:
- Macro: MEM_ARB_DM_PRIORITY_EN.
- Defined: fixed priority, dm always wins when both are valid. The round-robin pointer is removed. Grant lock still applies.
- Undefined: round-robin arbitration as above.

Test Plan:
- im only: im_req_addr=0x1000, bus_req_ready=1 → bus_req_addr=0x1000, wen=0, wmask=0 the same cycle. bus_resp_rdata=0xDEADBEEF next cycle → im_resp_valid=1, im_resp_rdata=0xDEADBEEF, dm_resp_valid=0.
- Both valid every cycle, ready=1: grants alternate im, dm, im, dm. Responses return in order, each routed to the matching port. With MEM_ARB_DM_PRIORITY_EN defined, dm wins every cycle.
- Stall stability: im valid with bus_req_ready=0 for 3 cycles, dm becomes valid in cycle 2 → bus_req_addr stays the im address until ready. dm is granted the next cycle.
- Full: OUTSTANDING=2, two requests accepted with no responses → bus_req_valid=0 and both readies 0. After one response, the next cycle accepts one request.
- Invalidate: one im fetch outstanding, assert im_invalidate_req → no im_invalidate_resp and no new im grants until the response arrives. Then im_invalidate_resp pulses exactly 1 cycle; dm requests are still accepted meanwhile.
- Async reset mid-stall with 2 outstanding → all outputs 0 immediately. After release, a stray bus_resp_valid is ignored, and a fresh im request is granted first.
